thresholding_cfg_sequencer: RTL
===============================

// Module: thresholding_cfg_sequencer
// PURPOSE
//  Loads the runtime threshold memories of a thresholding instance from a K-bit value stream.
//  Drives the cfg_* port of that instance: one write per accepted beat, in channel/threshold order.
//  An optional verify pass reads every threshold back and checks the readback count and strict ascending order per channel.
//  Sits between the host/DMA threshold stream and the thresholding cfg port.
// PARAMETERS
//  N           4      output precision of the thresholding instance (2^N-1 thresholds per channel)
//  K           8      threshold precision
//  C           4      channel count
//  PE          1      PEs of the thresholding instance; C%PE==0
//  SIGNED      1      ordering checks compare signed (1) or unsigned (0)
//  RB_TIMEOUT  256    max cycles without cfg_rack while reads are outstanding
// PORTS
//  clk       in   1        clock
//  rst       in   1        asynchronous active-high reset
//  start     in   1        1-cycle pulse; starts a sequence, ignored unless IDLE
//  verify    in   1        sampled with start; 1 = run the verify pass after load
//  busy      out  1        sequence in progress
//  done      out  1        1-cycle pulse at sequence end
//  err       out  3        sticky {timeout, rb_order, load_order}; cleared by start
//  s_tvalid  in   1        threshold stream valid
//  s_tready  out  1        threshold stream ready
//  s_tdata   in   K        threshold value
//  cfg_en    out  1        to thresholding cfg_en
//  cfg_we    out  1        to thresholding cfg_we
//  cfg_a     out  CLOG2(C/PE)+CLOG2(PE)+N   cfg address {cf, pe, ofs}
//  cfg_d     out  K        write data
//  cfg_rack  in   1        readback strobe, in issue order
//  cfg_q     in   K        readback data, valid with cfg_rack
// BEHAVIOUR
//  - Reset (async): state IDLE; busy, done, err, cfg_en, cfg_we, s_tready = 0; all counters 0.
//  - Address walk, shared by load and verify: ofs 0..2^N-2 (innermost), then pe 0..PE-1, then cf 0..C/PE-1.
//    Channel c = cf*PE+pe. Total beats T = C*(2^N-1). ofs 2^N-1 is never addressed.
//  - States: IDLE -> LOAD -> (verify? RDISS -> RDRAIN) -> FIN -> IDLE.
//  - IDLE: busy=0. On start: latch verify, clear err and counters, go to LOAD.
//  - LOAD: s_tready=1. cfg_en=cfg_we=s_tvalid; cfg_d=s_tdata; cfg_a=walk address (combinational).
//    Each handshake is one write, accepted the same cycle with no backpressure on cfg.
//    After beat T-1: go to RDISS if verify, else FIN.
//  - load_order check: for ofs>0, set err[0] if s_tdata <= previous beat (SIGNED compare). The first beat of each channel is unchecked.
//  - RDISS: s_tready=0; cfg_en=1, cfg_we=0 every cycle, one read per cycle, T reads total, then RDRAIN.
//    Outstanding counter = issued - racked (width CLOG2(T+1)).
//  - Readback side, active in RDISS and RDRAIN: each cfg_rack advances a separate return-index walk.
//    For ofs>0, set err[1] if cfg_q <= previous cfg_q. Racks while outstanding==0 are ignored.
//  - RDRAIN: cfg_en=0. Go to FIN when all T racks are received.
//    Timeout: a counter resets on each rack. If it reaches RB_TIMEOUT with outstanding>0, set err[2] and go to FIN.
//  - FIN: done=1 for one cycle, busy=0, then IDLE. busy=1 in LOAD/RDISS/RDRAIN.
//  - Same-cycle issue and rack: outstanding is unchanged.
//  - start while busy is ignored.
//  - Mid-operation reset: abort immediately, no done. The target memories are left partially written.
//  - cfg_a width is the thresholding cfg_a width; the pe field is absent when PE=1 and the cf field is absent when C/PE=1.
//  - Counters wrap only at their terminal counts above; no free-running wrap.
// TESTING
//  - N=2,C=2,PE=1,verify=0; stream 1,2,3,5,6,7 -> 6 writes; cfg_a=0,1,2,4,5,6; done 1 cycle after the 6th handshake; err=0.
//  - N=2,C=4,PE=2; channel 3 beats -> cfg_a={cf=1,pe=1,ofs}=0b1_1_00..10; s_tvalid gaps -> no cfg_en in gap cycles.
//  - Load 3,3,4 (N=2): err[0]=1 after 2nd beat, load continues, done still pulses; SIGNED=1 ordering -5<2 passes.
//  - verify=1, model returns racks 3 cycles after issue -> T consecutive reads, done after last rack, err=0; corrupt one cfg_q -> err[1].
//  - verify=1, model drops the last rack -> err[2] set RB_TIMEOUT cycles after the previous rack; done pulses.
//  - Assert rst during RDISS -> busy=0, cfg_en=0 immediately, no done; start after reset runs a clean sequence.

Source files
------------

// File: rtl/thresholding_cfg_sequencer.sv
// Streams K-bit thresholds into a thresholding instance's cfg port, then optionally
// reads them all back and checks the readback count and per-channel ascending order.
module thresholding_cfg_sequencer #(
    parameter  int N          = 4,
    parameter  int K          = 8,
    parameter  int C          = 4,
    parameter  int PE         = 1,
    parameter  int SIGNED     = 1,
    parameter  int RB_TIMEOUT = 256,
    localparam int NCF        = C / PE,
    localparam int CFB        = $clog2(NCF),
    localparam int PEB        = $clog2(PE),
    localparam int AW         = CFB + PEB + N
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          start_i,
    input  logic          verify_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [2:0]    err_o,
    input  logic          s_tvalid_i,
    output logic          s_tready_o,
    input  logic [K-1:0]  s_tdata_i,
    output logic          cfg_en_o,
    output logic          cfg_we_o,
    output logic [AW-1:0] cfg_a_o,
    output logic [K-1:0]  cfg_d_o,
    input  logic          cfg_rack_i,
    input  logic [K-1:0]  cfg_q_i
);

    localparam int T  = C * (2**N - 1);
    localparam int OW = $clog2(T + 1);
    localparam int TW = $clog2(RB_TIMEOUT + 1);
    localparam int CW = (CFB > 0) ? CFB : 1;
    localparam int PW = (PEB > 0) ? PEB : 1;

    localparam logic [N-1:0]  OFS_LAST = N'(2**N - 2);
    localparam logic [PW-1:0] PE_LAST  = PW'(PE - 1);
    localparam logic [CW-1:0] CF_LAST  = CW'(NCF - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(RB_TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, RDISS, RDRAIN, FIN} state_t;

    typedef struct packed {
        logic [CW-1:0] cf;
        logic [PW-1:0] pe;
        logic [N-1:0]  ofs;
    } walk_t;

    function automatic walk_t walk_next(input walk_t w);
        walk_t r;
        r = w;
        if (w.ofs == OFS_LAST) begin
            r.ofs = '0;
            if (w.pe == PE_LAST) begin
                r.pe = '0;
                r.cf = (w.cf == CF_LAST) ? '0 : w.cf + 1'b1;
            end else begin
                r.pe = w.pe + 1'b1;
            end
        end else begin
            r.ofs = w.ofs + 1'b1;
        end
        return r;
    endfunction

    function automatic logic walk_last(input walk_t w);
        return (w.ofs == OFS_LAST) && (w.pe == PE_LAST) && (w.cf == CF_LAST);
    endfunction

    // Shifts rather than a concatenation so absent (zero-width) pe/cf fields vanish cleanly.
    function automatic logic [AW-1:0] walk_addr(input walk_t w);
        return AW'(w.ofs) | (AW'(w.pe) << N) | (AW'(w.cf) << (N + PEB));
    endfunction

    function automatic logic not_above(input logic [K-1:0] a, input logic [K-1:0] b);
        if (SIGNED != 0) return $signed(a) <= $signed(b);
        else             return a <= b;
    endfunction

    state_t        state_q, state_d;
    logic          ver_q, ver_d;
    logic [2:0]    err_q, err_d;
    walk_t         iw_q, iw_d;
    walk_t         rw_q, rw_d;
    logic [K-1:0]  ld_prev_q, ld_prev_d;
    logic [K-1:0]  rb_prev_q, rb_prev_d;
    logic [OW-1:0] out_q, out_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          issue, rack_ok, rb_active;

    always_comb begin
        state_d    = state_q;
        ver_d      = ver_q;
        err_d      = err_q;
        iw_d       = iw_q;
        rw_d       = rw_q;
        ld_prev_d  = ld_prev_q;
        rb_prev_d  = rb_prev_q;
        out_d      = out_q;
        tmo_d      = tmo_q;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        s_tready_o = 1'b0;
        cfg_en_o   = 1'b0;
        cfg_we_o   = 1'b0;
        cfg_a_o    = walk_addr(iw_q);
        cfg_d_o    = s_tdata_i;
        issue      = 1'b0;
        rb_active  = (state_q == RDISS) || (state_q == RDRAIN);
        rack_ok    = rb_active && cfg_rack_i && (out_q != '0);

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    ver_d   = verify_i;
                    err_d   = '0;
                    iw_d    = '0;
                    rw_d    = '0;
                    out_d   = '0;
                    tmo_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                busy_o     = 1'b1;
                s_tready_o = 1'b1;
                cfg_en_o   = s_tvalid_i;
                cfg_we_o   = s_tvalid_i;
                if (s_tvalid_i) begin
                    ld_prev_d = s_tdata_i;
                    if (iw_q.ofs != '0 && not_above(s_tdata_i, ld_prev_q)) err_d[0] = 1'b1;
                    iw_d = walk_next(iw_q);
                    if (walk_last(iw_q)) state_d = ver_q ? RDISS : FIN;
                end
            end
            RDISS: begin
                busy_o   = 1'b1;
                cfg_en_o = 1'b1;
                issue    = 1'b1;
                iw_d     = walk_next(iw_q);
                if (walk_last(iw_q)) state_d = RDRAIN;
            end
            RDRAIN: begin
                busy_o = 1'b1;
            end
            FIN: begin
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Return side runs independently of the issue walk; racks arrive in issue order.
        if (rb_active) begin
            if (issue && !rack_ok)      out_d = out_q + 1'b1;
            else if (!issue && rack_ok) out_d = out_q - 1'b1;

            if (rack_ok) begin
                rb_prev_d = cfg_q_i;
                if (rw_q.ofs != '0 && not_above(cfg_q_i, rb_prev_q)) err_d[1] = 1'b1;
                rw_d  = walk_next(rw_q);
                tmo_d = '0;
                if (walk_last(rw_q) && state_q == RDRAIN) state_d = FIN;
            end else if (out_q != '0) begin
                tmo_d = tmo_q + 1'b1;
                if (tmo_q == TMO_LAST) begin
                    err_d[2] = 1'b1;
                    state_d  = FIN;
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            ver_q     <= 1'b0;
            err_q     <= '0;
            iw_q      <= '0;
            rw_q      <= '0;
            ld_prev_q <= '0;
            rb_prev_q <= '0;
            out_q     <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            ver_q     <= ver_d;
            err_q     <= err_d;
            iw_q      <= iw_d;
            rw_q      <= rw_d;
            ld_prev_q <= ld_prev_d;
            rb_prev_q <= rb_prev_d;
            out_q     <= out_d;
            tmo_q     <= tmo_d;
        end
    end

    assign err_o = err_q;

endmodule
